truth_table_sweeper: RTL
========================

# truth_table_sweeper

Self-test controller for the lab's 4-input combinational gate blocks, such as the "2-or-3-inputs-high" detector.
- On a start pulse it drives all 16 input combinations onto the gate under test and waits a programmable settle time per combination.
- It captures the gate output into a 16-bit truth table, compares that table against an expected constant, and reports pass/fail, the mismatch count and the first failing minterm.
- It sits beside the combinational gate on the lab board top level and replaces manual switch-toggling.

## Interface
Parameters:
- EXPECTED, 16'h7EE9: expected truth table. Bit m is the output for minterm m = {a,b,c,d}, with a as MSB. The default encodes "f=0 iff exactly one input high or all four high".
- SETTLE, 1: extra hold cycles per minterm before sampling. Legal range 0..15.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: launch a sweep. Sampled only when busy=0.
- f_in, input, 1: output of the gate under test.
- a, b, c, d, output, 1 each: registered drive to the gate under test.
- busy, output, 1: sweep in progress.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: the last completed sweep matched EXPECTED.
- table_out, output, 16: captured truth table of the last sweep.
- err_count, output, 5: number of mismatching minterms (0..16).
- first_err, output, 4: lowest mismatching minterm index.
- first_err_valid, output, 1: err_count != 0.

## Operation
States:
- IDLE: waiting for start.
- HOLD: current minterm applied; counter counting settle cycles.
- SAMPLE: f_in captured and compared.

Transitions:
- IDLE, start=1 at an edge: m<=0, {a,b,c,d}<=0000, hold counter<=SETTLE, busy<=1, go to HOLD. The same edge clears table_out, err_count, first_err, first_err_valid and pass.
- HOLD: counter==0 → SAMPLE. Otherwise decrement.
- SAMPLE edge:
  - table_out[m]<=f_in.
  - If f_in != EXPECTED[m]: increment err_count. If first_err_valid=0, set first_err<=m and first_err_valid<=1.
  - If m<15: m<=m+1, drive the new minterm, reload the counter, go to HOLD.
  - If m==15: {a,b,c,d}<=0000, busy<=0, done<=1, set pass from the final comparison (err_count including this sample ==0), go to IDLE.
- With SETTLE=0, HOLD lasts 0 cycles in effect: HOLD→SAMPLE is merged so each minterm is held exactly one cycle. This is an implementation choice, but the observable timing below is mandatory.

Rules:
- start while busy=1 is ignored.
- start sampled in the cycle where done=1 is legal and launches a new sweep.
- Results (table_out, err_count, first_err*, pass) hold until the next accepted start.
- rst_n low at any time, including mid-sweep: every output immediately goes to its reset value, the FSM goes to IDLE, and no done pulse is produced.
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, table_out=0, err_count=0, first_err=0, first_err_valid=0.
- err_count saturates naturally at 16; 5 bits, no wrap.

## Timing
- Each minterm is driven for SETTLE+1 cycles. f_in is sampled at the edge ending that window.
- Start accepted at edge E0:
  - minterm m is driven from edge E0+m·(SETTLE+1);
  - minterm m is sampled at edge E0+(m+1)·(SETTLE+1).
- Final sample is at E0+16·(SETTLE+1): 32 cycles for the default, 16 for SETTLE=0.
- done, pass and the final table_out/err_count are visible in the cycle after the final sample edge. busy falls on that same edge.
- Outputs a..d are registered; there is no combinational path from f_in or start to any output.

## Test plan
- Correct gate model on f_in, default params, start pulse → done exactly 32 cycles after the start edge, table_out=16'h7EE9, pass=1, err_count=0, first_err_valid=0.
- f_in tied 0 → table_out=16'h0000, err_count=11, first_err=0, first_err_valid=1, pass=0.
- Gate model with minterm 9 (abcd=1001) forced to 0 → table_out=16'h7CE9, err_count=1, first_err=9, pass=0.
- Start pulses at cycles 5 and 20 after the initial start → ignored; single done at cycle 32. Start held high in the done cycle → second sweep begins, done again 32 cycles later.
- rst_n pulsed low while minterm 5 is driven → all outputs 0 immediately, no done. Next start → full correct sweep, pass=1.
- SETTLE=0 with the correct gate → each minterm held one cycle, done 16 cycles after start, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks a 4-input gate through all 16 minterms and holds each one for
// SETTLE+1 cycles. The gate output is sampled at the edge that closes each
// window. The captured truth table is checked against EXPECTED, and the
// module reports pass/fail, the mismatch count and the first failing minterm.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'h7EE9,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid
);

  // The hold counter reloads to SETTLE and is 4 bits wide (range 0..15).
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  // Sampling happens on the same edge at which the hold counter is found
  // at zero. The "sample" step is therefore folded into HOLD. This gives
  // exactly SETTLE+1 cycles per minterm, including when SETTLE=0.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_m;
  logic [3:0]  r_cnt;
  logic [3:0]  r_abcd;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_table;
  logic [4:0]  r_err_count;
  logic [3:0]  r_first_err;
  logic        r_first_err_valid;

  logic        w_cnt_zero;
  logic        w_mismatch;
  logic        w_last;
  logic [4:0]  w_err_next;

  // Decode for the current sample: is the window over, and does the gate
  // output disagree with the expected table bit for this minterm?
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_mismatch = (f_in != EXPECTED[r_m]);
  assign w_last     = (r_m == 4'd15);
  // At most 16 mismatches are possible, so 5 bits can never wrap.
  assign w_err_next = r_err_count + 5'(w_mismatch);

  // Sweep FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_m               <= 4'd0;
      r_cnt             <= 4'd0;
      r_abcd            <= 4'd0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_table           <= 16'd0;
      r_err_count       <= 5'd0;
      r_first_err       <= 4'd0;
      r_first_err_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state           <= S_HOLD;
            r_m               <= 4'd0;
            r_abcd            <= 4'd0;
            r_cnt             <= SETTLE_CNT;
            r_busy            <= 1'b1;
            r_pass            <= 1'b0;
            r_table           <= 16'd0;
            r_err_count       <= 5'd0;
            r_first_err       <= 4'd0;
            r_first_err_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // End of the window: capture and compare this minterm.
            r_table[r_m] <= f_in;
            r_err_count  <= w_err_next;
            if (w_mismatch && !r_first_err_valid) begin
              r_first_err       <= r_m;
              r_first_err_valid <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_IDLE;
              r_abcd  <= 4'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 5'd0);
            end else begin
              r_m    <= r_m + 4'd1;
              r_abcd <= r_m + 4'd1;
              r_cnt  <= SETTLE_CNT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a               = r_abcd[3];
  assign b               = r_abcd[2];
  assign c               = r_abcd[1];
  assign d               = r_abcd[0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign table_out       = r_table;
  assign err_count       = r_err_count;
  assign first_err       = r_first_err;
  assign first_err_valid = r_first_err_valid;

endmodule
